pipe_reg_chain: RTL and testbench

Parametrised multi-stage pipeline register with run-time latency selection and valid tracking. It is the next generation of the single optional input/output register used on the DSP slice ports (A, B, C, D, M, P, opmode, carry). It is generalised to a DEPTH-deep delay line with a selectable tap, a valid sideband, a synchronous flush, and a fill counter that reports when the selected tap holds fresh data. Instances sit on every operand and result path of the DSP datapath, where balancing latency between paths is required.

---
 rtl/pipe_reg_chain.sv | 87 ++++++++
 tb/tb_pipe_reg_chain.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// DEPTH-deep delay line with run-time tap select, valid sideband, flush and fill counter.
// Optional build macro PIPE_REG_ZERO_INVALID_EN forces out to 0 whenever out_valid is low.

module pipe_reg_stage #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);
  // Flush kills the valid bit unconditionally but lets data keep shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (clk_en) q <= d;
      if (flush)       q_valid <= 1'b0;
      else if (clk_en) q_valid <= d_valid;
    end
  end
endmodule

module pipe_reg_chain #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic [LW-1:0]    lat_sel,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             primed
);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            vld_pipe;
  logic [LW-1:0]             fill_cnt;
  logic [LW-1:0]             lat;
  logic [WIDTH-1:0]          raw;

  assign dat_pipe[0] = d;
  assign vld_pipe[0] = d_valid;

  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .flush   (flush),
      .d       (dat_pipe[i-1]),
      .d_valid (vld_pipe[i-1]),
      .q       (dat_pipe[i]),
      .q_valid (vld_pipe[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               fill_cnt <= '0;
    else if (flush)                           fill_cnt <= '0;
    else if (clk_en && fill_cnt != DEPTH_L)   fill_cnt <= fill_cnt + LW'(1);
  end

  // Tap select is purely combinational so lat_sel changes take effect in-cycle.
  assign lat       = (lat_sel > DEPTH_L) ? DEPTH_L : lat_sel;
  assign raw       = dat_pipe[lat];
  assign out_valid = vld_pipe[lat];
  assign primed    = (fill_cnt >= lat);

`ifdef PIPE_REG_ZERO_INVALID_EN
  assign out = out_valid ? raw : '0;
`else
  assign out = raw;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=18, DEPTH=4): vector table plus corner sequences.

module tb_pipe_reg_chain;
  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n, clk_en, flush, d_valid;
  logic [LW-1:0]    lat_sel;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] out;
  logic             out_valid, primed;

  int pass_cnt = 0;
  int total_cnt = 0;

  pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .flush     (flush),
    .lat_sel   (lat_sel),
    .d         (d),
    .d_valid   (d_valid),
    .out       (out),
    .out_valid (out_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n, clk_en, flush;
    logic [LW-1:0]    lat_sel;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] e_out;
    logic             e_ov, e_pr;
  } vec_t;

  vec_t vecs[$];

  // Expected data for an invalid tap depends on the build option.
  function automatic logic [WIDTH-1:0] inv(input logic [WIDTH-1:0] raw);
`ifdef PIPE_REG_ZERO_INVALID_EN
    return '0;
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] eo,
                       input logic ev, input logic ep);
    total_cnt++;
    if (out === eo && out_valid === ev && primed === ep) pass_cnt++;
    else $display("FAIL %s: got out=%h ov=%b pr=%b, want out=%h ov=%b pr=%b",
                  name, out, out_valid, primed, eo, ev, ep);
  endtask

  task automatic drive(input logic r, input logic en, input logic fl,
                       input logic [LW-1:0] ls, input logic [WIDTH-1:0] dd,
                       input logic dv);
    rst_n = r; clk_en = en; flush = fl; lat_sel = ls; d = dd; d_valid = dv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    step();
    step();
  endtask

  function automatic vec_t mk(logic r, logic en, logic fl, logic [LW-1:0] ls,
                              logic [WIDTH-1:0] dd, logic dv,
                              logic [WIDTH-1:0] eo, logic ev, logic ep);
    vec_t v;
    v.rst_n = r; v.clk_en = en; v.flush = fl; v.lat_sel = ls; v.d = dd;
    v.d_valid = dv; v.e_out = eo; v.e_ov = ev; v.e_pr = ep;
    return v;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset and fill at lat 3, then load 20..23 and exercise tap saturation/switch.
    vecs.push_back(mk(0,1,0,3,  0,0,  0,0,0));
    vecs.push_back(mk(0,1,0,3,  0,0,  0,0,0));
    vecs.push_back(mk(1,1,0,3,  1,1,  0,0,0));
    vecs.push_back(mk(1,1,0,3,  2,1,  0,0,0));
    vecs.push_back(mk(1,1,0,3,  3,1,  1,1,1));
    vecs.push_back(mk(1,1,0,3,  4,1,  2,1,1));
    vecs.push_back(mk(1,1,0,3,  5,1,  3,1,1));
    vecs.push_back(mk(1,1,0,3, 20,1,  4,1,1));
    vecs.push_back(mk(1,1,0,3, 21,1,  5,1,1));
    vecs.push_back(mk(1,1,0,3, 22,1, 20,1,1));
    vecs.push_back(mk(1,1,0,3, 23,1, 21,1,1));
    vecs.push_back(mk(1,0,0,7, 99,1, 20,1,1));
    vecs.push_back(mk(1,0,0,4, 99,1, 20,1,1));
    vecs.push_back(mk(1,0,0,1, 99,1, 23,1,1));
    vecs.push_back(mk(1,0,0,2, 99,1, 22,1,1));
    vecs.push_back(mk(1,0,0,0, 99,1, 99,1,1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].clk_en, vecs[i].flush, vecs[i].lat_sel,
            vecs[i].d, vecs[i].d_valid);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_ov, vecs[i].e_pr);
    end

    // Bypass, including while reset is held.
    drive(1'b0, 1'b1, 1'b0, 0, 18'h2A5, 1'b1);
    #1 check("bypass_in_reset_comb", 18'h2A5, 1, 1);
    step();
    check("bypass_in_reset_edge", 18'h2A5, 1, 1);
    drive(1'b1, 1'b0, 1'b0, 0, 18'h155, 1'b0);
    #1 check("bypass_invalid", inv(18'h155), 0, 1);

    // Enable stall at lat 2.
    do_reset();
    drive(1,1,0,2, 10,1); step(); check("stall_fill1", 0, 0, 0);
    drive(1,1,0,2, 11,1); step(); check("stall_out10", 10, 1, 1);
    drive(1,0,0,2, 12,1); step(); check("stall_hold1", 10, 1, 1);
    drive(1,0,0,2, 12,1); step(); check("stall_hold2", 10, 1, 1);
    drive(1,1,0,2, 12,1); step(); check("stall_out11", 11, 1, 1);
    drive(1,1,0,2,  0,0); step(); check("stall_out12", 12, 1, 1);
    drive(1,1,0,2,  0,0); step(); check("stall_drain", inv(0), 0, 1);

    // Flush colliding with a valid input.
    drive(1,1,0,2, 7,1); step();
    drive(1,1,0,2, 8,1); step(); check("flush_pre7", 7, 1, 1);
    drive(1,1,1,2, 9,1); step(); check("flush_edge", inv(8), 0, 0);
    drive(1,1,0,2, 0,0); step(); check("flush_no9", inv(9), 0, 0);
    drive(1,1,0,2, 0,0); step(); check("flush_reprimed", inv(0), 0, 1);

    // Flush with clk_en low: valid/fill clear, data holds.
    drive(1,1,0,2, 5,1); step();
    drive(1,1,0,2, 6,1); step(); check("flush_noen_pre", 5, 1, 1);
    drive(1,0,1,2, 1,1); step(); check("flush_noen", inv(5), 0, 0);

    // Invalid data at lat 1 (build-dependent zeroing).
    drive(1,1,0,1, 18'h3FFFF,0); step(); check("zero_invalid", inv(18'h3FFFF), 0, 1);

    // Reset mid-stream discards in-flight data.
    drive(1,1,0,1, 3,1); step(); check("pre_reset_valid", 3, 1, 1);
    drive(0,1,0,1, 4,1); step(); check("reset_midstream", 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
endmodule
